// File: rtl/warp_pending_tracker_pkg.sv
// warp_pending_tracker_pkg: scheduler-shared drain FSM states and warp-id width helper.
package warp_pending_tracker_pkg;
  localparam int NUM_WARPS_DEF = 4;
  localparam int MAX_PENDING_DEF = 15;
  typedef enum logic [1:0] {DRAIN_IDLE, DRAIN_WAIT, DRAIN_DONE} drain_state_e;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int NW_W_DEF = id_w(NUM_WARPS_DEF);
endpackage

// File: rtl/warp_pending_tracker_if.sv
// warp_pending_tracker_if: issue, commit, drain and status signals of the pending tracker.
interface warp_pending_tracker_if #(
  parameter int NUM_WARPS = warp_pending_tracker_pkg::NUM_WARPS_DEF,
  parameter int NW_W = warp_pending_tracker_pkg::id_w(NUM_WARPS)
);
  logic                 issue_valid;
  logic [NW_W-1:0]      issue_wid;
  logic                 issue_ready;
  logic [NUM_WARPS-1:0] committed_warps;
  logic                 drain_valid;
  logic [NW_W-1:0]      drain_wid;
  logic                 drain_ready;
  logic                 drain_done;
  logic [NW_W-1:0]      drain_done_wid;
  logic [NUM_WARPS-1:0] pending_mask;
  logic                 busy;
  logic                 underflow_err;
  modport master (
    output issue_valid, issue_wid, committed_warps, drain_valid, drain_wid,
    input  issue_ready, drain_ready, drain_done, drain_done_wid, pending_mask, busy, underflow_err
  );
  modport slave (
    input  issue_valid, issue_wid, committed_warps, drain_valid, drain_wid,
    output issue_ready, drain_ready, drain_done, drain_done_wid, pending_mask, busy, underflow_err
  );
endinterface

// File: rtl/warp_pending_tracker_pending_counter.sv
// pending_counter: saturating in-flight counter; a same-cycle inc and dec cancel.
module pending_counter #(
  parameter int CTR_W = 4,
  parameter int MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] count,
  output logic             zero,
  output logic             full,
  output logic             underflow
);
  localparam logic [CTR_W-1:0] MAX_C = CTR_W'(MAX);
  logic [CTR_W-1:0] count_q, count_d;
  assign zero = count_q == '0;
  assign full = count_q == MAX_C;
  assign underflow = dec && !inc && zero;
  assign count = count_q;
  always_comb
    count_d = (inc && !dec && !full) ? count_q + CTR_W'(1) :
              (dec && !inc && !zero) ? count_q - CTR_W'(1) : count_q;
  always_ff @(posedge clk)
    count_q <= reset ? '0 : count_d;
endmodule

// File: rtl/warp_pending_tracker.sv
// warp_pending_tracker: per-warp in-flight counters with issue backpressure and a drain fence port.
module warp_pending_tracker
  import warp_pending_tracker_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEF,
  parameter int MAX_PENDING = MAX_PENDING_DEF
) (
  input logic clk,
  input logic reset,
  warp_pending_tracker_if.slave bus
);
  localparam int CTR_W = $clog2(MAX_PENDING + 1);
  localparam int NW_W = id_w(NUM_WARPS);
  logic [CTR_W-1:0]     cnt [NUM_WARPS];
  logic [NUM_WARPS-1:0] zero, full, uf;
  logic                 fire;
  drain_state_e         state_q, state_d;
  logic [NW_W-1:0]      drain_wid_q, drain_wid_d;
  logic                 underflow_err_q, underflow_err_d;
  // A full warp may still take an issue when its commit lands in the same cycle.
  assign bus.issue_ready = !(full[bus.issue_wid] && !bus.committed_warps[bus.issue_wid]) &&
                           !(state_q == DRAIN_WAIT && bus.issue_wid == drain_wid_q);
  assign fire = bus.issue_valid && bus.issue_ready;
  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_ctr
    pending_counter #(.CTR_W(CTR_W), .MAX(MAX_PENDING)) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .inc       (fire && bus.issue_wid == NW_W'(g)),
      .dec       (bus.committed_warps[g]),
      .count     (cnt[g]),
      .zero      (zero[g]),
      .full      (full[g]),
      .underflow (uf[g])
    );
  end
  always_comb begin
    state_d = state_q == DRAIN_IDLE ? (bus.drain_valid ? DRAIN_WAIT : DRAIN_IDLE) :
              state_q == DRAIN_WAIT ? (cnt[drain_wid_q] == '0 ? DRAIN_DONE : DRAIN_WAIT) :
              DRAIN_IDLE;
    drain_wid_d = (state_q == DRAIN_IDLE && bus.drain_valid) ? bus.drain_wid : drain_wid_q;
    underflow_err_d = underflow_err_q || |uf;
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? DRAIN_IDLE : state_d;
    drain_wid_q <= reset ? '0 : drain_wid_d;
    underflow_err_q <= reset ? 1'b0 : underflow_err_d;
  end
  assign bus.drain_ready = state_q == DRAIN_IDLE;
  assign bus.drain_done = state_q == DRAIN_DONE;
  assign bus.drain_done_wid = drain_wid_q;
  assign bus.pending_mask = ~zero;
  assign bus.busy = |(~zero);
  assign bus.underflow_err = underflow_err_q;
endmodule

// File: tb/tb_warp_pending_tracker.sv
// tb_warp_pending_tracker: directed and random stimulus against a count-per-warp reference model.
module tb_warp_pending_tracker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int ncmp = 0;
  int nfail = 0;
  int cnt_m [4];
  bit uf_m;
  int dmode_m;
  int dwid_m;
  warp_pending_tracker_if #(.NUM_WARPS(4), .NW_W(2)) bus ();
  warp_pending_tracker dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    foreach (cnt_m[w]) cnt_m[w] = 0;
    uf_m = 1'b0;
    dmode_m = 0;
    dwid_m = 0;
  endtask
  // Called just after a negedge: drive, check, advance the model across the next posedge.
  task automatic step(input bit iv, input logic [1:0] iw, input logic [3:0] cm,
                      input bit dv, input logic [1:0] dw);
    bit ready_e, fire;
    logic [3:0] mask_e;
    bus.issue_valid = iv;
    bus.issue_wid = iw;
    bus.committed_warps = cm;
    bus.drain_valid = dv;
    bus.drain_wid = dw;
    #1;
    ready_e = !(cnt_m[iw] == 15 && !cm[iw]) && !(dmode_m == 1 && int'(iw) == dwid_m);
    foreach (cnt_m[w]) mask_e[w] = cnt_m[w] != 0;
    chk("issue_ready", 32'(bus.issue_ready), 32'(ready_e));
    chk("drain_ready", 32'(bus.drain_ready), 32'(dmode_m == 0));
    chk("drain_done", 32'(bus.drain_done), 32'(dmode_m == 2));
    if (dmode_m == 2) chk("drain_done_wid", 32'(bus.drain_done_wid), 32'(dwid_m));
    chk("pending_mask", 32'(bus.pending_mask), 32'(mask_e));
    chk("busy", 32'(bus.busy), 32'(mask_e != 0));
    chk("underflow_err", 32'(bus.underflow_err), 32'(uf_m));
    @(posedge clk);
    fire = iv && ready_e;
    if (dmode_m == 0 && dv) begin dmode_m = 1; dwid_m = int'(dw); end
    else if (dmode_m == 1 && cnt_m[dwid_m] == 0) dmode_m = 2;
    else if (dmode_m == 2) dmode_m = 0;
    for (int w = 0; w < 4; w++) begin
      bit inc = fire && int'(iw) == w;
      if (inc && !cm[w]) cnt_m[w]++;
      else if (cm[w] && !inc) begin
        if (cnt_m[w] == 0) uf_m = 1'b1;
        else cnt_m[w]--;
      end
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.issue_valid = 1'b0;
    bus.committed_warps = '0;
    bus.drain_valid = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_drain_done_wid", 32'(bus.drain_done_wid), 32'd0);
    chk("reset_drain_done", 32'(bus.drain_done), 32'd0);
    chk("reset_pending_mask", 32'(bus.pending_mask), 32'd0);
  endtask
  initial begin
    bus.issue_valid = 1'b0;
    bus.issue_wid = '0;
    bus.committed_warps = '0;
    bus.drain_valid = 1'b0;
    bus.drain_wid = '0;
    @(negedge clk);
    do_reset();
    repeat (3) step(1, 2, 4'b0000, 0, 0);
    step(0, 0, 4'b0000, 0, 0);
    chk("ctr2_is_3", 32'(dut.cnt[2]), 32'd3);
    repeat (15) step(1, 1, 4'b0000, 0, 0);
    step(1, 1, 4'b0000, 0, 0);
    step(1, 1, 4'b0010, 0, 0);
    step(1, 1, 4'b0000, 0, 0);
    chk("ctr1_is_15", 32'(dut.cnt[1]), 32'd15);
    step(0, 0, 4'b0000, 1, 0);
    repeat (3) step(0, 0, 4'b0000, 0, 0);
    repeat (2) step(1, 3, 4'b0000, 0, 0);
    step(0, 0, 4'b0000, 1, 3);
    step(1, 3, 4'b0000, 0, 0);
    step(1, 0, 4'b0000, 0, 0);
    step(0, 0, 4'b1000, 0, 0);
    step(0, 0, 4'b1000, 0, 0);
    repeat (3) step(0, 0, 4'b0000, 0, 0);
    do_reset();
    step(1, 0, 4'b0001, 0, 0);
    step(0, 0, 4'b0000, 0, 0);
    step(0, 0, 4'b0001, 0, 0);
    repeat (3) step(0, 0, 4'b0000, 0, 0);
    do_reset();
    repeat (2) step(1, 1, 4'b0000, 0, 0);
    step(0, 0, 4'b0000, 1, 1);
    step(0, 0, 4'b0000, 0, 0);
    do_reset();
    repeat (2) step(0, 0, 4'b0000, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic [3:0] cm;
      for (int w = 0; w < 4; w++) cm[w] = $urandom_range(0, 4) == 0;
      if (n % 200 == 199) do_reset();
      else step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), cm,
                1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
